// File: rtl/clk_div_tick_counter.sv
// clk_div_tick_counter: counts rising edges of a selected clk_Divider output up to a terminal count.
// Define TICK_AUTO_RELOAD_EN to wrap the count and keep running instead of stopping in DONE.
module clk_div_tick_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Divide_2,
    input  logic             Divide_4,
    input  logic             Divide_8,
    input  logic             Divide_16,
    input  logic [1:0]       sel,
    input  logic [CNT_W-1:0] tc,
    input  logic             start,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] tc_q, tc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;
    logic             s_q, s_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic [3:0]       div_vec;
    logic             src_cur, src_new, rise, hit;

    assign div_vec   = {Divide_16, Divide_8, Divide_4, Divide_2};
    assign src_cur   = div_vec[sel_q];
    assign src_new   = div_vec[sel];
    assign rise      = src_cur & ~s_q;
    assign count_inc = count_q + CNT_W'(1);
    // An empty terminal count completes on the first RUN edge without ticking.
    assign hit       = (tc_q == '0) || (rise && (count_inc == tc_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            tc_q    <= '0;
            count_q <= '0;
            s_q     <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            sel_q   <= sel_d;
            tc_q    <= tc_d;
            count_q <= count_d;
            s_q     <= s_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN: begin
`ifndef TICK_AUTO_RELOAD_EN
                if (hit) state_d = DONE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d   = sel_q;
        tc_d    = tc_q;
        s_d     = s_q;
        count_d = count_q;
        tick_d  = 1'b0;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sel_d   = sel;
                    tc_d    = tc;
                    s_d     = src_new;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                s_d    = src_cur;
                done_d = hit;
                if (rise && (tc_q != '0)) begin
                    tick_d  = 1'b1;
                    count_d = count_inc;
`ifdef TICK_AUTO_RELOAD_EN
                    if (count_inc == tc_q) count_d = '0;
`endif
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy  = (state_q == RUN);
        tick  = tick_q;
        count = count_q;
        done  = done_q;
    end

endmodule

// File: tb/tb_clk_div_tick_counter.sv
// Scoreboard bench for clk_div_tick_counter: the driver pushes the expected tick/done events of each
// run, a negedge monitor pops and compares them as the DUT produces them.
module tb_clk_div_tick_counter;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       dc = 4'd0;
    logic [1:0]       sel = 2'd0;
    logic [CNT_W-1:0] tc = '0;
    logic             start = 1'b0;
    logic             tick, busy, done;
    logic [CNT_W-1:0] count;

    clk_div_tick_counter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .Divide_2  (dc[0]),
        .Divide_4  (dc[1]),
        .Divide_8  (dc[2]),
        .Divide_16 (dc[3]),
        .sel       (sel),
        .tc        (tc),
        .start     (start),
        .tick      (tick),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Free-running stand-in for clk_Divider.
    always @(posedge clk) dc <= dc + 4'd1;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {
        bit is_done;
        int cnt;
        int ratio;
        bit first;
        int lat;
        bit busy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   start_edge = 0;
    int   last_tick_edge = 0;
    int   ticks_seen = 0;
    bit   done_prev = 1'b0;

`ifdef TICK_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference model: a run on source ratio 2<<s yields ticks numbered 1..t spaced by the ratio,
    // with done on the last tick; auto-reload wraps the last tick to 0 and keeps going.
    function automatic void push_run(input int s, input int t);
        exp_t e;
        int   ratio = 2 << s;
        int   rounds = AUTO ? 2 : 1;
        if (t == 0) begin
            e = '{is_done: 1'b1, cnt: 0, ratio: ratio, first: 1'b0, lat: 1, busy: AUTO};
            sb.push_back(e);
            return;
        end
        for (int r = 0; r < rounds; r++) begin
            for (int i = 1; i <= t; i++) begin
                e = '{is_done: 1'b0, cnt: (AUTO && i == t) ? 0 : i, ratio: ratio,
                      first: (r == 0 && i == 1), lat: 0, busy: 1'b0};
                sb.push_back(e);
            end
            e = '{is_done: 1'b1, cnt: AUTO ? 0 : t, ratio: ratio, first: 1'b0, lat: -1, busy: AUTO};
            sb.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (tick === 1'b1) begin
            ticks_seen++;
            check("tick_expected", int'(sb.size() != 0 && !sb[0].is_done), 1);
            if (sb.size() != 0 && !sb[0].is_done) begin
                mon_e = sb.pop_front();
                check("tick_count", int'(count), mon_e.cnt);
                if (mon_e.first)
                    check("first_tick_window",
                          int'(edge_cnt - start_edge >= 1 && edge_cnt - start_edge <= mon_e.ratio), 1);
                else
                    check("tick_spacing", edge_cnt - last_tick_edge, mon_e.ratio);
            end
            last_tick_edge = edge_cnt;
        end
        if (done === 1'b1 && !done_prev) begin
            check("done_expected", int'(sb.size() != 0 && sb[0].is_done), 1);
            if (sb.size() != 0 && sb[0].is_done) begin
                mon_e = sb.pop_front();
                check("done_count", int'(count), mon_e.cnt);
                check("done_busy", int'(busy), int'(mon_e.busy));
                if (mon_e.lat < 0) check("done_on_last_tick", edge_cnt, last_tick_edge);
                else check("done_latency", edge_cnt - start_edge, mon_e.lat);
            end
        end
        if (AUTO && done === 1'b1) check("done_pulse_width", int'(done_prev), 0);
        done_prev = (done === 1'b1);
    end

    task automatic check_zero(input string tag);
        check({tag, "_tick"}, int'(tick), 0);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    task automatic do_start(input int s, input int t);
        @(negedge clk);
        #1;
        sel = s[1:0];
        tc = t[CNT_W-1:0];
        start = 1'b1;
        start_edge = edge_cnt + 1;
        push_run(s, t);
        @(negedge clk);
        #1;
        start = 1'b0;
        check("start_busy", int'(busy), 1);
        check("start_done_clr", int'(done), 0);
        check("start_count_clr", int'(count), 0);
    endtask

    task automatic run_to_end(input int budget, input bit jiggle);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            if (jiggle) begin
                sel = 2'($urandom_range(0, 3));
                tc = CNT_W'($urandom);
                start = busy && ($urandom_range(0, 5) == 0);
            end
        end
        start = 1'b0;
        check("run_within_budget", sb.size(), 0);
        sb.delete();
    endtask

    task automatic hold_check(input int t);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("hold_done", int'(done), 1);
            check("hold_busy", int'(busy), 0);
            check("hold_tick", int'(tick), 0);
            check("hold_count", int'(count), t);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check_zero("async_rst");
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, s, t;
        #3;
        check_zero("in_reset");
        #7;
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #1;
            check_zero("idle_after_reset");
        end

`ifndef TICK_AUTO_RELOAD_EN
        do_start(0, 5);
        run_to_end(200, 1'b0);
        hold_check(5);

        do_start(3, 2);
        run_to_end(200, 1'b1);
        hold_check(2);

        do_start(1, 0);
        run_to_end(50, 1'b0);
        hold_check(0);
        do_start(1, 3);
        run_to_end(100, 1'b0);
        hold_check(3);

        base = ticks_seen;
        do_start(2, 4);
        n = 0;
        while (ticks_seen < base + 2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("two_ticks_before_reset", int'(ticks_seen >= base + 2), 1);
        pulse_reset();
        repeat (40) begin
            @(negedge clk);
            #1;
            check_zero("idle_after_abort");
        end
        do_start(0, 2);
        run_to_end(100, 1'b0);
        hold_check(2);

        for (int i = 0; i < 12; i++) begin
            s = $urandom_range(0, 3);
            t = $urandom_range(0, 6);
            do_start(s, t);
            run_to_end(300, 1'b1);
            hold_check(t);
        end

        do_start(0, 255);
        run_to_end(700, 1'b0);
        hold_check(255);
`else
        do_start(0, 3);
        run_to_end(100, 1'b0);
        check("reload_busy", int'(busy), 1);
        pulse_reset();

        for (int i = 0; i < 5; i++) begin
            s = $urandom_range(0, 3);
            t = $urandom_range(1, 4);
            do_start(s, t);
            run_to_end(400, 1'b1);
            check("reload_busy", int'(busy), 1);
            pulse_reset();
        end
        repeat (20) begin
            @(negedge clk);
            #1;
            check_zero("idle_after_reset");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_tick_counter.md
CLK_DIV_TICK_COUNTER -- requirements
Module: clk_div_tick_counter

Interface
REQ-001 Parameter: CNT_W, default 8, width of the terminal-count input and the tick counter.
REQ-002 clk  in  1  system clock; the same clock that drives clk_Divider; all logic is rising-edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 Divide_2, Divide_4, Divide_8, Divide_16  in  1 each  divided-clock outputs of clk_Divider, synchronous to clk.
REQ-005 sel  in  2  source select: 0=Divide_2, 1=Divide_4, 2=Divide_8, 3=Divide_16.
REQ-006 tc  in  CNT_W  terminal count, i.e. the number of ticks to count.
REQ-007 start  in  1  one-cycle request to begin a counting run.
REQ-008 tick  out  1  registered one-cycle pulse on each rising edge of the selected source during RUN.
REQ-009 count  out  CNT_W  registered number of ticks counted in the current run.
REQ-010 busy  out  1  high while in RUN.
REQ-011 done  out  1  run-complete flag.

Function
REQ-012 FSM states: IDLE, RUN and DONE.
REQ-013 IDLE -> RUN on the rising edge where start=1; sel latches into sel_q and tc latches into tc_q at that edge; count clears to 0.
REQ-014 At the start edge, the edge-detect register s loads the currently selected source level, so a source that is already high produces no tick.
REQ-015 In RUN, each rising edge does s <= src(sel_q); if src(sel_q)=1 and s=0, the same edge sets tick=1 and count <= count+1. Otherwise tick=0.
REQ-016 Tick period in RUN equals the divide ratio: every 2, 4, 8 or 16 clk cycles for sel 0..3.
REQ-017 Changes on sel and tc during RUN are ignored; only the latched sel_q and tc_q are used.
REQ-018 start asserted during RUN is ignored.
REQ-019 When an edge increments count to tc_q, that edge moves the FSM to DONE and sets done=1.
REQ-020 tc=0 at start: the FSM enters RUN, then goes to DONE on the next edge with count=0 and no tick.
REQ-021 DONE: tick=0, busy=0, done=1 and count holds; start=1 re-enters RUN per REQ-013 and clears done at the same edge.
REQ-022 Counter arithmetic is unsigned modulo 2^CNT_W; tc=2^CNT_W-1 is legal and reached without overflow.
REQ-023 busy=1 exactly when state=RUN; tick is never asserted outside RUN.

Reset
REQ-024 rst=0 asynchronously forces state=IDLE, tick=0, count=0, busy=0, done=0, s=0, sel_q=0 and tc_q=0.
REQ-025 Reset asserted mid-run aborts the run with no done pulse; after release the block waits in IDLE for start.
REQ-026 Reset release is sampled synchronously; the first state change is possible on the first rising edge with rst=1.

Configuration
REQ-027 Macro TICK_AUTO_RELOAD_EN.
- Defined: on reaching tc_q, the FSM stays in RUN, count wraps to 0 on the same edge, done pulses high for exactly one cycle, and counting continues with tc_q; DONE is unreachable, and only reset stops the run.
- Undefined: behaviour is per REQ-019 and REQ-021.

Verification
REQ-028 Reset: rst=0 for 10 ns, then release with start=0 -> all outputs 0 and state stays IDLE for 100 ns.
REQ-029 sel=0, tc=5, start pulse -> 5 ticks spaced 2 clk apart, count steps 1..5, then done=1 and busy=0, and count holds at 5.
REQ-030 sel=3, tc=2 -> ticks 16 clk apart, done after the second tick; toggling sel and tc mid-run has no effect.
REQ-031 tc=0 with start -> done=1 one cycle after RUN entry, count=0, no tick; a second start from DONE with tc=3 and sel=1 -> 3 ticks 4 clk apart, done again.
REQ-032 sel=2, tc=4, rst pulsed low after the second tick -> outputs 0 immediately and no done; a later start counts from 0.
REQ-033 With TICK_AUTO_RELOAD_EN: sel=0, tc=3 -> done pulses for 1 cycle every 6 clk, count sequence 1,2,0,1,2,0, and busy stays high.
